// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: op encodings, flag bit
// positions and FSM state encoding.
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SLT = 3'b110
  } alu_op_e;

  // flags vector is {negative, zero, overflow, carry}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  localparam int FLAG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Four-cycle command sequencer: capture a register-register command, read
// operands, run the ALU, write the result back (register 0 is never written).
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_WIDTH-1:0]   cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rs,
  input  logic [ADDR_WIDTH-1:0] cmd_rt,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  output logic [ADDR_WIDTH-1:0] rf_read0_addr,
  output logic [ADDR_WIDTH-1:0] rf_read1_addr,
  input  logic [DATA_WIDTH-1:0] rf_read0_data,
  input  logic [DATA_WIDTH-1:0] rf_read1_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [FLAG_W-1:0]     alu_flags,
  output logic [FLAG_W-1:0]     flags,
  output logic                  done
);

  seq_state_e state_q, state_d;

  logic [OP_WIDTH-1:0]   op_q;
  logic [ADDR_WIDTH-1:0] rs_q, rt_q, rd_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [FLAG_W-1:0]     flags_next_q;
  logic                  accept;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    rf_we     = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: begin
        done    = 1'b1;
        rf_we   = (rd_q != '0);
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= '0;
      result_q     <= '0;
      flags_next_q <= '0;
      flags        <= '0;
    end else begin
      if (accept) begin
        op_q <= cmd_op;
        rs_q <= cmd_rs;
        rt_q <= cmd_rt;
        rd_q <= cmd_rd;
      end
      if (state_q == ST_READ) begin
        alu_a    <= rf_read0_data;
        alu_b    <= rf_read1_data;
        alu_ctrl <= op_q;
      end
      if (state_q == ST_EXEC) begin
        result_q     <= alu_result;
        flags_next_q <= alu_flags;
      end
      // flags only become visible once the command retires
      if (state_q == ST_WRITE) flags <= flags_next_q;
    end
  end

  // addresses come straight from registers so the file register sees stable inputs
  assign rf_read0_addr = rs_q;
  assign rf_read1_addr = rt_q;
  assign rf_write_addr = rd_q;
  assign rf_write_data = result_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench: behavioural file register and ALU around the sequencer, with a
// reference register array updated per command.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [4:0]  rf_read0_addr, rf_read1_addr;
  logic [31:0] rf_read0_data, rf_read1_data;
  logic        rf_we;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc;

  logic [31:0] rf [32] = '{default: 32'h0};
  logic [31:0] ref_rf [32];
  logic [3:0]  ref_flags;
  logic        pl_we = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [35:0] alu_out;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .rf_read0_addr(rf_read0_addr), .rf_read1_addr(rf_read1_addr),
    .rf_read0_data(rf_read0_data), .rf_read1_data(rf_read1_data),
    .rf_we(rf_we), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .flags(flags), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {flags[3:0], result[31:0]} of a reference ALU
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic v, c;
    s = '0; r = '0; v = 1'b0; c = 1'b0;
    case (op)
      3'b001: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                    v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b010: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = s[32];
                    v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b011: r = a & b;
      3'b100: r = a | b;
      3'b101: r = a ^ b;
      3'b110: r = {31'b0, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return {r[31], (r == 32'h0), v, c, r};
  endfunction

  assign alu_out       = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_result    = alu_out[31:0];
  assign alu_flags     = alu_out[35:32];
  assign rf_read0_data = rf[rf_read0_addr];
  assign rf_read1_data = rf[rf_read1_addr];

  always @(posedge clk) begin
    if (pl_we) rf[pl_addr] <= pl_data;
    else if (rf_we && rf_write_addr != 5'd0) rf[rf_write_addr] <= rf_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // called and returns at a negedge
  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    @(negedge clk);
    pl_we = 1'b0;
    if (a != 5'd0) ref_rf[a] = d;
  endtask

  // called at a negedge; returns at the negedge after the write cycle
  task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit hold);
    logic [35:0] e;
    e = alu_fn(ref_rf[rs], ref_rf[rt], op);
    cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    chk("ready_idle", cmd_ready, 1);
    last_acc = cyc;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("ready_busy", cmd_ready, 0);
      chk("done", done, (k == 3));
      chk("rf_we", rf_we, (k == 3) && (rd != 5'd0));
      chk("rd0_addr", rf_read0_addr, rs);
      chk("rd1_addr", rf_read1_addr, rt);
      if (k == 2) begin
        chk("alu_a", alu_a, ref_rf[rs]);
        chk("alu_b", alu_b, ref_rf[rt]);
        chk("alu_ctrl", alu_ctrl, op);
      end
      if (k == 3) begin
        chk("wr_addr", rf_write_addr, rd);
        chk("wr_data", rf_write_data, e[31:0]);
      end
    end
    @(negedge clk);
    if (rd != 5'd0) ref_rf[rd] = e[31:0];
    ref_flags = e[35:32];
    chk("flags", flags, ref_flags);
    chk("done_after", done, 0);
    chk("rf_dest", rf[rd], ref_rf[rd]);
    if (!hold) cmd_valid = 1'b0;
  endtask

  initial begin
    int a0, a1, a2;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    ref_flags = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_wdata", rf_write_data, 0);
    rst = 1'b0;

    // basic add
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    issue(3'b001, 5'd1, 5'd2, 5'd3, 1'b0);
    chk("add_r3", rf[3], 32'd12);

    // equal subtract sets zero flag
    preload(5'd4, 32'h1234);
    preload(5'd5, 32'h1234);
    issue(3'b010, 5'd4, 5'd5, 5'd6, 1'b0);
    chk("sub_zero_flag", flags[2], 1);
    chk("sub_r6", rf[6], 0);

    // write to r0 suppressed, flags still update
    issue(3'b001, 5'd1, 5'd2, 5'd0, 1'b0);
    chk("r0_stays_zero", rf[0], 0);

    // back-to-back with held valid and a read-after-write hazard
    issue(3'b001, 5'd1, 5'd2, 5'd3, 1'b1); a0 = last_acc;
    issue(3'b001, 5'd3, 5'd1, 5'd7, 1'b1); a1 = last_acc;
    issue(3'b101, 5'd7, 5'd3, 5'd8, 1'b0); a2 = last_acc;
    chk("accept_gap1", a1 - a0, 4);
    chk("accept_gap2", a2 - a1, 4);
    chk("hazard_r7", rf[7], 32'd17);

    // reset while in EXEC drops the command
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_exec_ready", cmd_ready, 1);
    chk("rst_exec_we", rf_we, 0);
    chk("rst_exec_done", done, 0);
    chk("rst_exec_flags", flags, 0);
    ref_flags = '0;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_exec_idle_we", rf_we, 0);
    end
    chk("rst_exec_r9", rf[9], ref_rf[9]);

    // randomized commands over a small register window to provoke hazards
    for (int i = 1; i < 8; i++) preload(5'(i), $urandom);
    preload(5'd3, 32'h7fff_ffff);
    preload(5'd4, 32'h8000_0000);
    for (int n = 0; n < 60; n++) begin
      issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          chk("idle_ready", cmd_ready, 1);
          chk("idle_done", done, 0);
        end
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) chk("final_rf", rf[i], ref_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
